mem_access_ctrl: RTL and testbench

//  Initiator side of the MFA/MFC memory handshake: accepts one load/store request from the SPARC

---
 rtl/sparc_mem_pkg.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC MFA/MFC memory initiator: opcodes, FSM states
// and access-size/alignment helpers.
package sparc_mem_pkg;

  localparam logic [5:0] LDUB = 6'b000001;
  localparam logic [5:0] LDUH = 6'b000010;
  localparam logic [5:0] LDD  = 6'b000011;
  localparam logic [5:0] ST   = 6'b000100;
  localparam logic [5:0] STB  = 6'b000101;
  localparam logic [5:0] STH  = 6'b000110;
  localparam logic [5:0] STD  = 6'b000111;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] LDSB = 6'b001001;
  localparam logic [5:0] LDSH = 6'b001010;

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE, S_RESP} state_t;

  typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE, SZ_BAD} acc_size_t;

  function automatic acc_size_t access_size(input logic [5:0] op);
    case (op)
      LDUB, LDSB, STB: return SZ_BYTE;
      LDUH, LDSH, STH: return SZ_HALF;
      LD, ST:          return SZ_WORD;
      LDD, STD:        return SZ_DOUBLE;
      default:         return SZ_BAD;
    endcase
  endfunction

  function automatic logic is_aligned(input acc_size_t sz, input logic [2:0] low);
    case (sz)
      SZ_BYTE:   return 1'b1;
      SZ_HALF:   return low[0] == 1'b0;
      SZ_WORD:   return low[1:0] == 2'b00;
      SZ_DOUBLE: return low == 3'b000;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == LD) || (op == LDUB) || (op == LDUH) ||
           (op == LDSB) || (op == LDSH) || (op == LDD);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// MFA/MFC four-phase memory initiator; splits ldd/std into two word beats.
// Optional MFC wait timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
  import sparc_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_wdata2,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] rsp_rdata2,
  output logic        rsp_err,
  output logic        MFA,
  input  logic        MFC,
  output logic [5:0]  mem_opcode,
  output logic [8:0]  mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_nx;
  logic [5:0]  op_q;
  logic [8:0]  addr_q;
  logic [31:0] wdata_q, wdata2_q, cap0_q, cap1_q, rdata_q, rdata2_q;
  logic        beat_q, err_q, rsp_err_q;
  logic        req_bad, is_double, tmo_hit;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign req_bad   = (access_size(req_op) == SZ_BAD) ||
                     !is_aligned(access_size(req_op), req_addr[2:0]);
  assign is_double = (op_q == LDD) || (op_q == STD);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Zero outside S_ASSERT, so every beat starts counting from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  tmo_cnt <= '0;
    else if (state == S_ASSERT) tmo_cnt <= tmo_cnt + CW'(1);
    else                        tmo_cnt <= '0;
  end

  assign tmo_hit = (state == S_ASSERT) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (req_valid) state_nx = req_bad ? S_RESP : S_ASSERT;
      S_ASSERT:  if (MFC || tmo_hit) state_nx = S_RELEASE;
      S_RELEASE: if (!MFC) state_nx = (is_double && !beat_q && !err_q) ? S_ASSERT : S_RESP;
      S_RESP:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wdata2_q  <= '0;
      cap0_q    <= '0;
      cap1_q    <= '0;
      beat_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rdata2_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q     <= req_op;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          wdata2_q <= req_wdata2;
          beat_q   <= 1'b0;
          err_q    <= req_bad;
          if (req_bad) begin
            rsp_err_q <= 1'b1;
            rdata_q   <= '0;
            rdata2_q  <= '0;
          end
        end
        S_ASSERT: begin
          if (MFC) begin
            if (beat_q) cap1_q <= mem_rdata;
            else        cap0_q <= mem_rdata;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
        // Response registers change only on entry to S_RESP so they hold between responses.
        S_RELEASE: if (!MFC) begin
          if (state_nx == S_ASSERT) begin
            beat_q <= 1'b1;
          end else begin
            rsp_err_q <= err_q;
            rdata_q   <= (!err_q && is_load(op_q)) ? cap0_q : '0;
            rdata2_q  <= (!err_q && op_q == LDD) ? cap1_q : '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready   = (state == S_IDLE);
    MFA         = (state == S_ASSERT);
    rsp_valid   = (state == S_RESP);
    mem_opcode  = op_q;
    if (op_q == LDD)      mem_opcode = LD;
    else if (op_q == STD) mem_opcode = ST;
    mem_address = addr_q + {6'b000000, beat_q, 2'b00};
    mem_wdata   = beat_q ? wdata2_q : wdata_q;
  end

  assign rsp_rdata  = rdata_q;
  assign rsp_rdata2 = rdata2_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-addressed big-endian RAM responder,
// vector table, reset/timeout sequences and randomized traffic against a word-level model.
module tb_mem_access_ctrl;
  import sparc_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [5:0]  req_op;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata, req_wdata2;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, rsp_rdata2;
  logic        MFA, MFC;
  logic [5:0]  mem_opcode;
  logic [8:0]  mem_address;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wdata2(req_wdata2),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rdata2(rsp_rdata2), .rsp_err(rsp_err),
    .MFA(MFA), .MFC(MFC), .mem_opcode(mem_opcode), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RAM responder: MFC after wait_lim cycles of MFA, held rel_lim cycles after MFA drops
  logic [7:0]  ram [512];
  int unsigned wait_lim = 0, rel_lim = 0, wait_cnt = 0, hold_cnt = 0;
  logic        mfc_ovr = 1'b0, mfc_ovr_val = 1'b0;

  assign MFC = mfc_ovr ? mfc_ovr_val : ((MFA && (wait_cnt >= wait_lim)) || (hold_cnt != 0));

  function automatic logic [31:0] ram_rd(input logic [5:0] op, input logic [8:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = ram[a]; b1 = ram[9'(a + 9'd1)]; b2 = ram[9'(a + 9'd2)]; b3 = ram[9'(a + 9'd3)];
    case (op)
      LD:      return {b0, b1, b2, b3};
      LDUB:    return {24'h0, b0};
      LDSB:    return {{24{b0[7]}}, b0};
      LDUH:    return {16'h0, b0, b1};
      LDSH:    return {{16{b0[7]}}, b0, b1};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) mem_rdata <= ram_rd(mem_opcode, mem_address);

  always @(posedge clk) begin
    if (MFA && MFC) begin
      case (mem_opcode)
        ST: begin
          ram[mem_address]             <= mem_wdata[31:24];
          ram[9'(mem_address + 9'd1)]  <= mem_wdata[23:16];
          ram[9'(mem_address + 9'd2)]  <= mem_wdata[15:8];
          ram[9'(mem_address + 9'd3)]  <= mem_wdata[7:0];
        end
        STH: begin
          ram[mem_address]             <= mem_wdata[15:8];
          ram[9'(mem_address + 9'd1)]  <= mem_wdata[7:0];
        end
        STB: ram[mem_address] <= mem_wdata[7:0];
        default: ;
      endcase
      hold_cnt <= rel_lim;
    end else if (hold_cnt != 0) begin
      hold_cnt <= hold_cnt - 1;
    end
    wait_cnt <= MFA ? wait_cnt + 1 : 0;
  end

  // Protocol monitor: MFA pulses, four-phase rule, request stability while MFA high
  logic [8:0]  pulse_addr [$];
  logic [5:0]  pulse_op   [$];
  logic        mfa_prev = 1'b0, mfc_prev = 1'b0;
  logic [8:0]  last_addr;
  logic [5:0]  last_op;
  logic [31:0] last_wd;
  int unsigned proto_viol = 0, stab_viol = 0;

  always @(negedge clk) begin
    if (MFA && !mfa_prev) begin
      pulse_addr.push_back(mem_address);
      pulse_op.push_back(mem_opcode);
      if (mfc_prev) proto_viol++;
    end
    if (MFA && mfa_prev &&
        (mem_address != last_addr || mem_opcode != last_op || mem_wdata != last_wd))
      stab_viol++;
    mfa_prev  = MFA;
    mfc_prev  = MFC;
    last_addr = mem_address;
    last_op   = mem_opcode;
    last_wd   = mem_wdata;
  end

  // Reference model: big-endian memory held as 32-bit words
  logic [31:0] ref_word [128];

  function automatic int unsigned op_size(input logic [5:0] op);
    case (op)
      LDUB, LDSB, STB: return 1;
      LDUH, LDSH, STH: return 2;
      LD, ST:          return 4;
      LDD, STD:        return 8;
      default:         return 0;
    endcase
  endfunction

  function automatic logic is_st(input logic [5:0] op);
    return (op == ST) || (op == STB) || (op == STH) || (op == STD);
  endfunction

  function automatic logic [31:0] ref_get(input int unsigned a, input int unsigned n);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++)
      v = (v << 8) | ((ref_word[(a + i) / 4] >> (8 * (3 - (a + i) % 4))) & 32'hFF);
    return v;
  endfunction

  task automatic ref_put(input int unsigned a, input int unsigned n, input logic [31:0] v);
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned ad;
      int unsigned sh;
      logic [31:0] byt;
      ad  = a + i;
      sh  = 8 * (3 - ad % 4);
      byt = (v >> (8 * (n - 1 - i))) & 32'hFF;
      ref_word[ad / 4] = (ref_word[ad / 4] & ~(32'hFF << sh)) | (byt << sh);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [5:0] op, input int unsigned a);
    logic [31:0] v;
    case (op)
      LDUB:    v = ref_get(a, 1);
      LDSB:    begin v = ref_get(a, 1); if (v[7])  v = v | 32'hFFFFFF00; end
      LDUH:    v = ref_get(a, 2);
      LDSH:    begin v = ref_get(a, 2); if (v[15]) v = v | 32'hFFFF0000; end
      default: v = ref_get(a, 4);
    endcase
    return v;
  endfunction

  // One transaction; caller is at a negedge with the DUT idle
  task automatic do_txn(input string tag, input logic [5:0] op, input logic [8:0] addr,
                        input logic [31:0] wd, input logic [31:0] wd2,
                        input int unsigned w, input int unsigned r,
                        input logic e_err, input logic [31:0] e_rd, input logic [31:0] e_rd2,
                        input int unsigned e_lat, input int unsigned e_pulses);
    int unsigned lat;
    logic [5:0]  beat_op;
    wait_lim = w;
    rel_lim  = r;
    pulse_addr.delete();
    pulse_op.delete();
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_wdata2 = wd2;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    // Request is latched; keep valid high with garbage to show it is ignored while busy
    req_op = 6'($urandom); req_addr = 9'($urandom); req_wdata = $urandom; req_wdata2 = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    check({tag, "_lat"}, lat, e_lat);
    check({tag, "_err"}, 32'(rsp_err), 32'(e_err));
    if (!e_err) check({tag, "_rdata"}, rsp_rdata, e_rd);
    if (!e_err && op == LDD) check({tag, "_rdata2"}, rsp_rdata2, e_rd2);
    check({tag, "_pulses"}, 32'(pulse_addr.size()), e_pulses);
    beat_op = (op == LDD) ? LD : (op == STD) ? ST : op;
    for (int unsigned i = 0; i < e_pulses && i < pulse_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(pulse_addr[i]), 32'(addr) + 4 * i);
      check($sformatf("%s_op%0d", tag, i), 32'(pulse_op[i]), 32'(beat_op));
    end
    @(negedge clk);
    check({tag, "_pulse1"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    if (!e_err && is_st(op)) begin
      if (op == STD) begin
        ref_put(addr, 4, wd);
        ref_put(32'(addr) + 4, 4, wd2);
      end else begin
        ref_put(addr, op_size(op), wd);
      end
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [8:0]  addr;
    logic [31:0] wd, wd2;
    int unsigned w, r;
    logic        err;
    logic [31:0] rd, rd2;
    int unsigned lat, pulses;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  logic [5:0] ops     [10];
  logic [5:0] bad_ops [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{ST,   9'h010, 32'hDEADBEEF, 32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        3,  1};
    tbl[1]  = '{LD,   9'h010, 32'h0,        32'h0,        0, 0, 1'b0, 32'hDEADBEEF, 32'h0,        3,  1};
    tbl[2]  = '{STB,  9'h021, 32'h000000F0, 32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        3,  1};
    tbl[3]  = '{LDSB, 9'h021, 32'h0,        32'h0,        0, 0, 1'b0, 32'hFFFFFFF0, 32'h0,        3,  1};
    tbl[4]  = '{LDUB, 9'h021, 32'h0,        32'h0,        0, 0, 1'b0, 32'h000000F0, 32'h0,        3,  1};
    tbl[5]  = '{STD,  9'h040, 32'h11111111, 32'h22222222, 0, 0, 1'b0, 32'h0,        32'h0,        5,  2};
    tbl[6]  = '{LDD,  9'h040, 32'h0,        32'h0,        0, 0, 1'b0, 32'h11111111, 32'h22222222, 5,  2};
    tbl[7]  = '{LDUH, 9'h031, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,        32'h0,        1,  0};
    tbl[8]  = '{LD,   9'h042, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,        32'h0,        1,  0};
    tbl[9]  = '{STH,  9'h032, 32'h0000ABCD, 32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        3,  1};
    tbl[10] = '{LDSH, 9'h032, 32'h0,        32'h0,        0, 0, 1'b0, 32'hFFFFABCD, 32'h0,        3,  1};
    tbl[11] = '{LDUH, 9'h032, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0000ABCD, 32'h0,        3,  1};
    tbl[12] = '{STD,  9'h1F8, 32'hA5A50001, 32'h5A5A0002, 2, 1, 1'b0, 32'h0,        32'h0,        11, 2};
    tbl[13] = '{LDD,  9'h1F8, 32'h0,        32'h0,        0, 0, 1'b0, 32'hA5A50001, 32'h5A5A0002, 5,  2};
    tbl[14] = '{6'h3F, 9'h000, 32'h0,       32'h0,        0, 0, 1'b1, 32'h0,        32'h0,        1,  0};
    tbl[15] = '{LDD,  9'h044, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,        32'h0,        1,  0};
    tbl[16] = '{LD,   9'h010, 32'h0,        32'h0,        3, 2, 1'b0, 32'hDEADBEEF, 32'h0,        8,  1};
    tbl[17] = '{LD,   9'h020, 32'h0,        32'h0,        0, 0, 1'b0, 32'h00F00000, 32'h0,        3,  1};

    ops     = '{LD, LDUB, LDUH, LDSB, LDSH, LDD, ST, STB, STH, STD};
    bad_ops = '{6'h00, 6'h3F, 6'h10};

    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    for (int i = 0; i < 128; i++) ref_word[i] = 32'h0;

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_wdata2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(req_ready), 32'd1);
    check("rst_mfa",    32'(MFA), 32'd0);
    check("rst_valid",  32'(rsp_valid), 32'd0);
    check("rst_err",    32'(rsp_err), 32'd0);
    check("rst_rdata",  rsp_rdata, 32'h0);
    check("rst_rdata2", rsp_rdata2, 32'h0);
    check("rst_maddr",  32'(mem_address), 32'h0);
    check("rst_mop",    32'(mem_opcode), 32'h0);
    check("rst_mwd",    mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      do_txn($sformatf("v%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].wd2,
             tbl[i].w, tbl[i].r, tbl[i].err, tbl[i].rd, tbl[i].rd2, tbl[i].lat, tbl[i].pulses);

    // Reset while MFA is high: request discarded, no response
    begin
      int unsigned seen;
      wait_lim = 50;
      req_valid = 1'b1; req_op = LD; req_addr = 9'h010;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("mid_mfa_high", 32'(MFA), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_mfa_drop", 32'(MFA), 32'd0);
      check("mid_maddr", 32'(mem_address), 32'h0);
      seen = 0;
      repeat (2) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      reset = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (rsp_valid || MFA) seen++;
      end
      check("mid_no_rsp", seen, 0);
      do_txn("mid_after", LD, 9'h010, 32'h0, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, 32'h0, 3, 1);
    end

`ifdef MEM_TIMEOUT_EN
    mfc_ovr = 1'b1; mfc_ovr_val = 1'b0;
    do_txn("tmo_ld",  LD,  9'h010, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 32'h0, 18, 1);
    do_txn("tmo_ldd", LDD, 9'h040, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 32'h0, 18, 1);
    mfc_ovr = 1'b0;
`else
    do_txn("slow_ld", LD, 9'h010, 32'h0, 32'h0, 40, 0, 1'b0, 32'hDEADBEEF, 32'h0, 43, 1);
`endif

    for (int k = 0; k < 200; k++) begin
      logic [5:0]  op;
      int unsigned sz, ai, w, r, np, lat;
      logic        e;
      logic [31:0] wd, wd2, rd, rd2;
      if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 2)];
      else                           op = ops[$urandom_range(0, 9)];
      sz = op_size(op);
      ai = $urandom_range(0, 511);
      if (sz != 0 && $urandom_range(0, 3) != 0) ai = ai - ai % sz;
      e   = (sz == 0) || (ai % sz != 0);
      w   = $urandom_range(0, 3);
      r   = $urandom_range(0, 2);
      wd  = $urandom;
      wd2 = $urandom;
      np  = e ? 0 : ((sz == 8) ? 2 : 1);
      lat = e ? 1 : np * (w + r + 2) + 1;
      rd  = (e || is_st(op)) ? 32'h0 : ref_load(op, ai);
      rd2 = (!e && op == LDD) ? ref_get(ai + 4, 4) : 32'h0;
      do_txn($sformatf("r%0d", k), op, 9'(ai), wd, wd2, w, r, e, rd, rd2, lat, np);
    end

    check("four_phase", proto_viol, 0);
    check("mem_stable", stab_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
